// File: rtl/cr_huf_comp_sc_fifo_pf_pkg.sv
// Shared Huffman-compressor types: end-of-block code and default symbol-count FIFO entry layout.
package cr_huf_compPKG;

  typedef enum logic [1:0] {
    PIPE_NO_EOB  = 2'd0,
    PIPE_EOB_BLK = 2'd1,
    PIPE_EOB_FRM = 2'd2,
    PIPE_EOB_ALL = 2'd3
  } e_pipe_eob;

  // Default 15-bit entry; eob always occupies bits [1:0].
  typedef struct packed {
    logic        vld;
    logic        long_sym;
    logic [10:0] seq_id;
    e_pipe_eob   eob;
  } s_sc_fifo_entry;

  localparam int unsigned SC_EOB_W = 2;

  function automatic logic sc_has_eob(input logic [SC_EOB_W-1:0] eob);
    return e_pipe_eob'(eob) != PIPE_NO_EOB;
  endfunction

endpackage

// File: rtl/cr_huf_comp_sc_fifo_ram.sv
// Flop-array 1R1W memory with registered read data (one-cycle read latency).
module cr_huf_comp_sc_fifo_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 15,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address read and write returns the old entry, which the full-RAM case relies on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cr_huf_comp_sc_fifo_pf.sv
// Symbol-count stream FIFO: input flop, RAM, read-in-flight slot and 2-entry prefetch output buffer.
module cr_huf_comp_sc_fifo_pf
  import cr_huf_compPKG::*;
#(
  parameter int unsigned DATA_W     = 15,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RDY_MARGIN = 4,
  parameter int unsigned CW         = $clog2(DEPTH + 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_wr,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rdy,
  input  logic              out_rd,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     used_slots,
  output logic [CW-1:0]     free_slots,
  output logic [CW-1:0]     frame_cnt,
  output logic [CW-1:0]     hwm,
  input  logic              err_clr,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] CAP      = CW'(DEPTH + 3);
  localparam logic [AW:0]   RAM_FULL = (AW + 1)'(DEPTH);

  logic              in_vld_q;
  logic [DATA_W-1:0] in_data_q;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       ram_cnt;
  logic              rd_inflight;
  logic [DATA_W-1:0] ram_rdata;
  logic              buf_vld0, buf_vld1;
  logic [DATA_W-1:0] buf_data0, buf_data1;
  logic [CW-1:0]     used_q, frame_q, hwm_q;
  logic              ovf_q, udf_q;

  logic              full, accept, pop, push;
  logic              ram_we, ram_re;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ;
  logic              in_eob, out_eob;
  logic              ovf_set, udf_set;
  logic [CW-1:0]     used_nxt, frame_nxt, hwm_nxt;

  // used_slots == CAP exactly when the input flop is stuck behind a full RAM and a full
  // buffer, so the capacity check alone guarantees the input flop can take a new entry.
  always_comb begin
    full    = (used_q == CAP);
    accept  = in_wr & ~clear & ~full;
    pop     = out_rd & buf_vld0 & ~clear;
    push    = rd_inflight & ~clear;
    ovf_set = in_wr & ~clear & full;
    udf_set = out_rd & ~buf_vld0 & ~clear;
    in_eob  = sc_has_eob(in_data[SC_EOB_W-1:0]);
    out_eob = sc_has_eob(buf_data0[SC_EOB_W-1:0]);
  end

  // The same-cycle pop is credited to the buffer so a continuous read stream never bubbles.
  always_comb begin
    buf_cnt = {1'b0, buf_vld0} + {1'b0, buf_vld1};
    occ     = 3'(buf_cnt) + 3'(rd_inflight) - 3'(pop);
    ram_re  = ~clear & (ram_cnt != '0) & (occ < 3'd2);
    ram_we  = ~clear & in_vld_q & ((ram_cnt != RAM_FULL) | ram_re);
  end

  always_comb begin
    used_nxt  = '0;
    frame_nxt = '0;
    hwm_nxt   = '0;
    if (!clear) begin
      used_nxt  = used_q + CW'(accept) - CW'(pop);
      frame_nxt = frame_q + CW'(accept & in_eob) - CW'(pop & out_eob);
      if (!err_clr) hwm_nxt = (used_nxt > hwm_q) ? used_nxt : hwm_q;
    end
  end

  cr_huf_comp_sc_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (in_data_q),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld_q    <= 1'b0;
      in_data_q   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (accept) in_data_q <= in_data;
      if (clear)       in_vld_q <= 1'b0;
      else if (accept) in_vld_q <= 1'b1;
      else if (ram_we) in_vld_q <= 1'b0;
      if (clear) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        ram_cnt <= '0;
      end else begin
        if (ram_we) wr_ptr <= wr_ptr + 1'b1;
        if (ram_re) rd_ptr <= rd_ptr + 1'b1;
        ram_cnt <= ram_cnt + (AW + 1)'(ram_we) - (AW + 1)'(ram_re);
      end
      rd_inflight <= ram_re;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld0  <= 1'b0;
      buf_vld1  <= 1'b0;
      buf_data0 <= '0;
      buf_data1 <= '0;
    end else if (clear) begin
      buf_vld0 <= 1'b0;
      buf_vld1 <= 1'b0;
    end else begin
      case ({pop, push})
        2'b10: begin
          buf_data0 <= buf_data1;
          buf_vld0  <= buf_vld1;
          buf_vld1  <= 1'b0;
        end
        2'b01: begin
          if (!buf_vld0) begin
            buf_data0 <= ram_rdata;
            buf_vld0  <= 1'b1;
          end else begin
            buf_data1 <= ram_rdata;
            buf_vld1  <= 1'b1;
          end
        end
        2'b11: begin
          if (buf_vld1) begin
            buf_data0 <= buf_data1;
            buf_data1 <= ram_rdata;
          end else begin
            buf_data0 <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q  <= '0;
      frame_q <= '0;
      hwm_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      used_q  <= used_nxt;
      frame_q <= frame_nxt;
      hwm_q   <= hwm_nxt;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (udf_set)      udf_q <= 1'b1;
      else if (err_clr) udf_q <= 1'b0;
    end
  end

  always_comb begin
    out_vld       = buf_vld0;
    out_data      = buf_data0;
    used_slots    = used_q;
    free_slots    = CAP - used_q;
    in_rdy        = free_slots > CW'(RDY_MARGIN);
    frame_cnt     = frame_q;
    hwm           = hwm_q;
    overflow_err  = ovf_q;
    underflow_err = udf_q;
  end

endmodule

// File: tb/tb_cr_huf_comp_sc_fifo_pf.sv
// Directed self-checking bench for cr_huf_comp_sc_fifo_pf (DEPTH=256, capacity 259).
module tb_cr_huf_comp_sc_fifo_pf;

  localparam int unsigned DATA_W = 15;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CW     = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_wr = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_rdy;
  logic              out_rd = 1'b0;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     used_slots, free_slots, frame_cnt, hwm;
  logic              err_clr = 1'b0;
  logic              overflow_err, underflow_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cr_huf_comp_sc_fifo_pf #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .RDY_MARGIN (4),
    .CW         (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_wr         (in_wr),
    .in_data       (in_data),
    .in_rdy        (in_rdy),
    .out_rd        (out_rd),
    .out_vld       (out_vld),
    .out_data      (out_data),
    .used_slots    (used_slots),
    .free_slots    (free_slots),
    .frame_cnt     (frame_cnt),
    .hwm           (hwm),
    .err_clr       (err_clr),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_vld",  32'(out_vld), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_used",     32'(used_slots), 32'd0);
    chk("rst_free",     32'(free_slots), 32'd259);
    chk("rst_frame",    32'(frame_cnt), 32'd0);
    chk("rst_hwm",      32'(hwm), 32'd0);
    chk("rst_in_rdy",   32'(in_rdy), 32'd1);
    chk("rst_ovf",      32'(overflow_err), 32'd0);
    chk("rst_udf",      32'(underflow_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single entry latency
    in_wr = 1'b1; in_data = 15'h4A81;
    tick();
    in_wr = 1'b0;
    chk("t1_used",   32'(used_slots), 32'd1);
    chk("t1_frame",  32'(frame_cnt), 32'd1);
    chk("t1_vld_e0", 32'(out_vld), 32'd0);
    tick();
    chk("t1_vld_e1", 32'(out_vld), 32'd0);
    tick();
    chk("t1_vld_e2", 32'(out_vld), 32'd0);
    tick();
    chk("t1_vld_e3", 32'(out_vld), 32'd1);
    chk("t1_data",   32'(out_data), 32'h4A81);
    chk("t1_hwm",    32'(hwm), 32'd1);
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;
    chk("t1_pop_vld",   32'(out_vld), 32'd0);
    chk("t1_pop_used",  32'(used_slots), 32'd0);
    chk("t1_pop_frame", 32'(frame_cnt), 32'd0);

    // 2: 20 back-to-back writes, then 20 pops without bubbles
    for (int i = 0; i < 20; i++) begin
      in_wr = 1'b1; in_data = 15'('h100 + i);
      tick();
    end
    in_wr = 1'b0;
    idle(5);
    chk("t2_used",  32'(used_slots), 32'd20);
    chk("t2_frame", 32'(frame_cnt), 32'd15);
    chk("t2_hwm",   32'(hwm), 32'd20);
    out_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t2_pop_vld",  32'(out_vld), 32'd1);
      chk("t2_pop_data", 32'(out_data), 32'('h100 + i));
      tick();
    end
    out_rd = 1'b0;
    chk("t2_end_vld",  32'(out_vld), 32'd0);
    chk("t2_end_used", 32'(used_slots), 32'd0);
    chk("t2_end_hwm",  32'(hwm), 32'd20);

    // 3: fill to capacity, in_rdy threshold, overflow drop
    for (int k = 0; k < 259; k++) begin
      chk("t3_in_rdy", 32'(in_rdy), (259 - k > 4) ? 32'd1 : 32'd0);
      in_wr = 1'b1; in_data = 15'(k * 4 + 1);
      tick();
    end
    in_wr = 1'b0;
    chk("t3_full_used", 32'(used_slots), 32'd259);
    chk("t3_full_free", 32'(free_slots), 32'd0);
    chk("t3_full_ovf",  32'(overflow_err), 32'd0);
    in_wr = 1'b1; in_data = 15'h7FFD;
    tick();
    in_wr = 1'b0;
    chk("t3_ovf",   32'(overflow_err), 32'd1);
    chk("t3_used",  32'(used_slots), 32'd259);
    chk("t3_frame", 32'(frame_cnt), 32'd259);
    chk("t3_hwm",   32'(hwm), 32'd259);
    idle(3);
    out_rd = 1'b1;
    for (int k = 0; k < 259; k++) begin
      chk("t3_pop_vld",  32'(out_vld), 32'd1);
      chk("t3_pop_data", 32'(out_data), 32'(k * 4 + 1));
      tick();
    end
    out_rd = 1'b0;
    chk("t3_end_used",  32'(used_slots), 32'd0);
    chk("t3_end_frame", 32'(frame_cnt), 32'd0);
    chk("t3_end_vld",   32'(out_vld), 32'd0);

    // 4: underflow, err_clr, set-wins-over-clear
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;
    chk("t4_udf",   32'(underflow_err), 32'd1);
    chk("t4_used",  32'(used_slots), 32'd0);
    chk("t4_frame", 32'(frame_cnt), 32'd0);
    chk("t4_hwm",   32'(hwm), 32'd259);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr_ovf", 32'(overflow_err), 32'd0);
    chk("t4_clr_udf", 32'(underflow_err), 32'd0);
    chk("t4_clr_hwm", 32'(hwm), 32'd0);
    err_clr = 1'b1; out_rd = 1'b1;
    tick();
    err_clr = 1'b0; out_rd = 1'b0;
    chk("t4_setwin_udf", 32'(underflow_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_reclr_udf", 32'(underflow_err), 32'd0);

    // 5: concurrent write and pop at occupancy 5
    for (int j = 0; j < 5; j++) begin
      in_wr = 1'b1; in_data = 15'('h200 + j);
      tick();
    end
    in_wr = 1'b0;
    idle(5);
    for (int c = 0; c < 100; c++) begin
      in_wr = 1'b1; in_data = 15'('h205 + c); out_rd = 1'b1;
      chk("t5_vld",  32'(out_vld), 32'd1);
      chk("t5_data", 32'(out_data), 32'('h200 + c));
      chk("t5_used", 32'(used_slots), 32'd5);
      tick();
    end
    in_wr = 1'b0; out_rd = 1'b0;
    chk("t5_end_used", 32'(used_slots), 32'd5);

    // 6: clear with 10 held plus concurrent write and pop
    for (int j = 0; j < 5; j++) begin
      in_wr = 1'b1; in_data = 15'('h269 + j);
      tick();
    end
    in_wr = 1'b0;
    idle(5);
    chk("t6_pre_used",  32'(used_slots), 32'd10);
    chk("t6_pre_frame", 32'(frame_cnt), 32'd7);
    chk("t6_pre_hwm",   32'(hwm), 32'd10);
    chk("t6_pre_data",  32'(out_data), 32'h264);
    clear = 1'b1; in_wr = 1'b1; in_data = 15'h3333; out_rd = 1'b1;
    tick();
    clear = 1'b0; in_wr = 1'b0; out_rd = 1'b0;
    chk("t6_vld",   32'(out_vld), 32'd0);
    chk("t6_used",  32'(used_slots), 32'd0);
    chk("t6_free",  32'(free_slots), 32'd259);
    chk("t6_frame", 32'(frame_cnt), 32'd0);
    chk("t6_hwm",   32'(hwm), 32'd0);
    chk("t6_ovf",   32'(overflow_err), 32'd0);
    chk("t6_udf",   32'(underflow_err), 32'd0);
    idle(3);
    chk("t6_idle_vld", 32'(out_vld), 32'd0);
    in_wr = 1'b1; in_data = 15'h1235;
    tick();
    in_wr = 1'b0;
    idle(2);
    chk("t6_wr_vld_e2", 32'(out_vld), 32'd0);
    tick();
    chk("t6_wr_vld_e3", 32'(out_vld), 32'd1);
    chk("t6_wr_data",   32'(out_data), 32'h1235);
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;

    // clear while a RAM read is in flight discards it
    in_wr = 1'b1; in_data = 15'h7777;
    tick();
    in_wr = 1'b0;
    idle(2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_inflt_vld",  32'(out_vld), 32'd0);
    chk("t6_inflt_used", 32'(used_slots), 32'd0);
    tick();
    chk("t6_inflt_vld2", 32'(out_vld), 32'd0);

    // sticky error survives clear
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_sticky_udf", 32'(underflow_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
